tick_stretch: RTL and testbench

- Output-side counterpart to the switch debouncer. The debouncer turns a long bouncy level into a one-cycle tick; this block turns one-cycle ticks into clean, human-visible pulses on an LED or indicator pin.
- Each accepted tick produces exactly one high pulse of fixed width, followed by a mandatory low gap, so back-to-back events stay individually visible.
- Ticks that arrive during a pulse or gap are queued in a saturating pending counter and replayed in order.

---
 rtl/tick_stretch.sv | 77 +++++++
 tb/tb_tick_stretch.sv | 134 +++++++++++++
 2 files changed

// File: rtl/tick_stretch.sv
// tick_stretch: stretches one-cycle ticks into fixed-width LED pulses with enforced low gaps and a saturating replay queue
module tick_stretch #(
  parameter int ON_BITS  = 22,
  parameter int OFF_BITS = 21,
  parameter int PEND_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              clr,
  output logic              led,
  output logic              done_tick,
  output logic              ovf_tick,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              busy
);
  localparam int QW = ON_BITS > OFF_BITS ? ON_BITS : OFF_BITS;
  localparam logic [QW-1:0] ON_LOAD = QW'((64'd1 << ON_BITS) - 64'd1);
  localparam logic [QW-1:0] OFF_LOAD = QW'((64'd1 << OFF_BITS) - 64'd1);
  localparam logic [QW-1:0] Q_ONE = QW'(1);
  localparam logic [PEND_W-1:0] P_ONE = PEND_W'(1);
  localparam logic [PEND_W-1:0] PMAX = '1;
  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
  state_t state, state_n;
  logic [QW-1:0] q, q_n;
  logic [PEND_W-1:0] pend_n;
  logic inc, dec, last_off, ovf_n;
  // a tick on the final gap cycle is counted before the replay consumes it
  always_comb begin
    inc = tick && !clr && state != IDLE;
    last_off = state == OFF && q == '0;
    dec = last_off && !clr && (pend_cnt != '0 || inc);
    ovf_n = inc && !dec && pend_cnt == PMAX;
    pend_n = clr ? '0 :
             (inc && !dec && !ovf_n) ? pend_cnt + P_ONE :
             (dec && !inc) ? pend_cnt - P_ONE : pend_cnt;
    state_n = state;
    q_n = q;
    case (state)
      IDLE: if (tick && !clr) begin
        state_n = ON;
        q_n = ON_LOAD;
      end
      ON: if (q == '0) begin
        state_n = OFF;
        q_n = OFF_LOAD;
      end else q_n = q - Q_ONE;
      OFF: if (q != '0) q_n = q - Q_ONE;
      else if (dec) begin
        state_n = ON;
        q_n = ON_LOAD;
      end else state_n = IDLE;
      default: begin
        state_n = IDLE;
        q_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      q <= '0;
      pend_cnt <= '0;
      led <= 1'b0;
      done_tick <= 1'b0;
      ovf_tick <= 1'b0;
    end else begin
      state <= state_n;
      q <= q_n;
      pend_cnt <= pend_n;
      led <= state_n == ON;
      done_tick <= state == ON && q == '0;
      ovf_tick <= ovf_n;
    end
  end
  assign busy = state != IDLE || pend_cnt != '0;
endmodule

// File: tb/tb_tick_stretch.sv
// tb_tick_stretch: directed scoreboard bench; expected led rises, done and overflow strobes are queued per test
module tb_tick_stretch;
  logic clk = 1'b0, reset = 1'b1, tick = 1'b0, clr = 1'b0;
  logic led, done_tick, ovf_tick, busy;
  logic [1:0] pend_cnt;
  int cyc = 0, base = 0, checks = 0, errors = 0;
  typedef struct {int kind; int cyc;} ev_t;
  typedef struct {int c; int sig; int val;} pt_t;
  ev_t exp_q[$];
  pt_t pt_q[$];

  tick_stretch #(.ON_BITS(3), .OFF_BITS(2), .PEND_W(2)) dut (
    .clk(clk), .reset(reset), .tick(tick), .clr(clr), .led(led),
    .done_tick(done_tick), .ovf_tick(ovf_tick), .pend_cnt(pend_cnt), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  task automatic ev(input int k, input int c);
    exp_q.push_back('{k, c});
  endtask

  task automatic pt(input int c, input int s, input int v);
    pt_q.push_back('{c, s, v});
  endtask

  // kind 0 = led rise, 1 = done_tick, 2 = ovf_tick
  task automatic see(input int kind, input int c);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: got kind %0d at cycle %0d, expected none", kind, c);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != c) begin
        errors++;
        $display("FAIL event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d", kind, c, e.kind, e.cyc);
      end
    end
  endtask

  initial begin
    logic led_prev;
    int rc;
    led_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rc = cyc - base;
      if (led && !led_prev) see(0, rc);
      if (done_tick) see(1, rc);
      if (ovf_tick) see(2, rc);
      led_prev = led;
    end
  end

  task automatic run(input string name, input logic [63:0] tv, input logic [63:0] cv, input int rlo, input int rhi);
    int got;
    @(negedge clk);
    base = cyc;
    for (int c = 0; c < 64; c++) begin
      if (c > 0) @(negedge clk);
      tick = tv[c];
      clr = cv[c];
      if (c == rlo) begin
        reset = 1'b0;
        #1;
        chk({name, " async led"}, int'(led), 0);
        chk({name, " async pend"}, int'(pend_cnt), 0);
        chk({name, " async busy"}, int'(busy), 0);
      end
      if (c == rhi) reset = 1'b1;
      foreach (pt_q[i]) if (pt_q[i].c == c) begin
        got = pt_q[i].sig == 0 ? int'(led) : pt_q[i].sig == 1 ? int'(pend_cnt) : int'(busy);
        chk($sformatf("%s c%0d sig%0d", name, c, pt_q[i].sig), got, pt_q[i].val);
      end
    end
    tick = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    chk({name, " events left"}, exp_q.size(), 0);
    exp_q.delete();
    pt_q.delete();
  endtask

  initial begin
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset led", int'(led), 0);
    chk("reset done", int'(done_tick), 0);
    chk("reset ovf", int'(ovf_tick), 0);
    chk("reset pend", int'(pend_cnt), 0);
    chk("reset busy", int'(busy), 0);
    reset = 1'b1;

    ev(0, 11); ev(1, 19);
    pt(15, 1, 0); pt(18, 0, 1); pt(19, 0, 0); pt(19, 1, 0); pt(22, 2, 1); pt(23, 2, 0);
    run("single", 64'd1 << 10, 64'd0, -1, -1);

    ev(0, 11); ev(1, 19); ev(0, 23); ev(1, 31); ev(0, 35); ev(1, 43);
    pt(14, 1, 1); pt(21, 1, 2); pt(23, 1, 1); pt(35, 1, 0); pt(46, 2, 1); pt(47, 2, 0);
    run("three", (64'd1 << 10) | (64'd1 << 13) | (64'd1 << 20), 64'd0, -1, -1);

    ev(0, 11); ev(2, 16); ev(2, 17); ev(1, 19); ev(0, 23); ev(1, 31);
    ev(0, 35); ev(1, 43); ev(0, 47); ev(1, 55);
    pt(18, 1, 3); pt(23, 1, 2); pt(58, 2, 1); pt(59, 2, 0);
    run("saturate", (64'd1 << 10) | (64'd31 << 12), 64'd0, -1, -1);

    ev(0, 11); ev(1, 19); ev(0, 23); ev(1, 31); ev(0, 35); ev(1, 43); ev(0, 47); ev(1, 55);
    pt(23, 1, 0); pt(27, 1, 1); pt(35, 1, 1); pt(47, 1, 0); pt(59, 2, 0);
    run("final_off", (64'd1 << 10) | (64'd1 << 22) | (64'd1 << 26) | (64'd1 << 34), 64'd0, -1, -1);

    ev(0, 11); ev(1, 19);
    pt(14, 1, 2); pt(16, 1, 0); pt(18, 0, 1); pt(22, 2, 1); pt(23, 2, 0); pt(31, 0, 0); pt(31, 2, 0);
    run("clr", (64'd1 << 10) | (64'd1 << 12) | (64'd1 << 13) | (64'd1 << 30), (64'd1 << 15) | (64'd1 << 30), -1, -1);

    ev(0, 11); ev(0, 21); ev(1, 29);
    pt(14, 1, 1); pt(14, 0, 1); pt(28, 0, 1); pt(29, 0, 0); pt(33, 2, 0);
    run("reset_mid", (64'd1 << 10) | (64'd1 << 12) | (64'd1 << 20), 64'd0, 15, 17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
